// File: rtl/arb_mux_np.sv
// N-channel arbitrating multiplexer with valid/ready flow control, round-robin or
// fixed-priority grant, and one registered output stage tagged with the source index.
module arb_mux_np #(
   parameter int N  = 2,
   parameter int D  = 16,
   parameter int RR = 1,
   localparam int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [D-1:0]  i_data [N],
   input  logic [N-1:0]  i_valid,
   output logic [N-1:0]  o_ready,
   output logic [D-1:0]  o_data,
   output logic [SW-1:0] o_sel,
   output logic          o_valid,
   input  logic          i_ready
);

   logic [SW-1:0] ptr;
   logic [SW-1:0] gidx;
   logic          found;
   logic          load_en;
   logic          xfer;

   assign load_en = !o_valid || i_ready;
   assign xfer    = found && load_en;

   // Scan starts at ptr in round-robin mode and at 0 in fixed-priority mode;
   // the wrap uses an explicit compare so non-power-of-two N never aliases.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      gidx  = '0;
      for (int k = 0; k < N; k++) begin
         if (RR != 0) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
         end else begin
            idx = k;
         end
         if (!found && i_valid[SW'(idx)]) begin
            found = 1'b1;
            gidx  = SW'(idx);
         end
      end
   end

   always_comb begin
      o_ready = '0;
      if (i_rst_n && xfer) o_ready[gidx] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data  <= '0;
         o_sel   <= '0;
         o_valid <= 1'b0;
         ptr     <= '0;
      end else begin
         if (xfer) begin
            o_data  <= i_data[gidx];
            o_sel   <= gidx;
            o_valid <= 1'b1;
            if (RR != 0) begin
               if (gidx == SW'(N - 1)) ptr <= '0;
               else                    ptr <= gidx + 1'b1;
            end
         end else if (i_ready) begin
            // Drained with nothing to load: data/sel keep their last value.
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_np.sv
// Bench for arb_mux_np: three instances (N=4 round-robin, N=4 fixed priority,
// N=3 round-robin) share one stimulus stream and are checked against a rule model.
module tb_arb_mux_np;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_data [4];
   logic [15:0] d3 [3];
   logic [3:0]  in_valid;
   logic        in_ready;

   logic [3:0]  ready4r, ready4f;
   logic [2:0]  ready3;
   logic [15:0] data4r, data4f, data3;
   logic [1:0]  sel4r, sel4f, sel3;
   logic        valid4r, valid4f, valid3;

   int tests_run  = 0;
   int fail_count = 0;
   int xfers      = 0;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      for (int k = 0; k < 3; k++) d3[k] = in_data[k];
   end

   arb_mux_np #(.N(4), .D(16), .RR(1)) u_rr4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(in_data), .i_valid(in_valid),
      .o_ready(ready4r), .o_data(data4r), .o_sel(sel4r), .o_valid(valid4r),
      .i_ready(in_ready));

   arb_mux_np #(.N(4), .D(16), .RR(0)) u_fp4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(in_data), .i_valid(in_valid),
      .o_ready(ready4f), .o_data(data4f), .o_sel(sel4f), .o_valid(valid4f),
      .i_ready(in_ready));

   arb_mux_np #(.N(3), .D(16), .RR(1)) u_rr3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(d3), .i_valid(in_valid[2:0]),
      .o_ready(ready3), .o_data(data3), .o_sel(sel3), .o_valid(valid3),
      .i_ready(in_ready));

   logic [3:0]  act_ready [3];
   logic [15:0] act_data  [3];
   logic [1:0]  act_sel   [3];
   logic        act_valid [3];

   assign act_ready[0] = ready4r;          assign act_ready[1] = ready4f;
   assign act_ready[2] = {1'b0, ready3};
   assign act_data[0]  = data4r;           assign act_data[1]  = data4f;
   assign act_data[2]  = data3;
   assign act_sel[0]   = sel4r;            assign act_sel[1]   = sel4f;
   assign act_sel[2]   = sel3;
   assign act_valid[0] = valid4r;          assign act_valid[1] = valid4f;
   assign act_valid[2] = valid3;

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_count++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          nch [3] = '{4, 4, 3};
   int          rrm [3] = '{1, 0, 1};
   bit          m_valid [3];
   logic [15:0] m_data  [3];
   int          m_sel   [3];
   int          m_ptr   [3];
   logic [17:0] exp_q [$];

   function automatic logic [3:0] vmask(input int m);
      return (nch[m] == 4) ? 4'hF : 4'h7;
   endfunction

   // Winner under the arbitration rule, or -1 when nobody requests.
   function automatic int exp_grant(input int m, input logic [3:0] v);
      int c;
      for (int k = 0; k < nch[m]; k++) begin
         c = (rrm[m] != 0) ? (m_ptr[m] + k) % nch[m] : k;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready(input int m);
      int g;
      if (!rst_n) return 4'b0;
      if (m_valid[m] && !in_ready) return 4'b0;
      g = exp_grant(m, in_valid & vmask(m));
      if (g < 0) return 4'b0;
      return 4'(1 << g);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < 3; m++) begin
            m_valid[m] <= 1'b0;
            m_data[m]  <= 16'h0;
            m_sel[m]   <= 0;
            m_ptr[m]   <= 0;
         end
         exp_q.delete();
      end else begin
         for (int m = 0; m < 3; m++) begin
            int g;
            g = exp_grant(m, in_valid & vmask(m));
            if ((!m_valid[m] || in_ready) && g >= 0) begin
               m_data[m]  <= in_data[g];
               m_sel[m]   <= g;
               m_valid[m] <= 1'b1;
               if (rrm[m] != 0) m_ptr[m] <= (g + 1) % nch[m];
               if (m == 0) exp_q.push_back({2'(g), in_data[g]});
            end else if (in_ready) begin
               m_valid[m] <= 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare + scoreboard ----------------
   always @(negedge clk) begin
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("ready%0d", m), 32'(act_ready[m]), 32'(exp_ready(m)));
         chk($sformatf("valid%0d", m), 32'(act_valid[m]), 32'(m_valid[m]));
         chk($sformatf("data%0d", m),  32'(act_data[m]),  32'(m_data[m]));
         chk($sformatf("sel%0d", m),   32'(act_sel[m]),   32'(m_sel[m]));
      end
      if (rst_n && act_valid[0] && in_ready) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            fail_count++;
            $display("FAIL sb_underflow actual=word_out required=none at %0t", $time);
         end else begin
            chk("sb_word", 32'({act_sel[0], act_data[0]}), 32'(exp_q.pop_front()));
            xfers++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   int exp_rr4 [6] = '{0, 1, 2, 3, 0, 1};
   int exp_rr3 [6] = '{0, 1, 2, 0, 1, 2};
   int xfers_snap;

   initial begin
      rst_n    = 1'b0;
      in_ready = 1'b1;
      in_valid = 4'b1111;
      for (int k = 0; k < 4; k++) in_data[k] = 16'hA000 + 16'(k);

      // Reset with all channels requesting
      repeat (2) @(posedge clk);
      #2;
      chk("rst_ready",  32'(ready4r), 32'h0);
      chk("rst_valid",  32'(valid4r), 32'h0);
      chk("rst_data",   32'(data4r),  32'h0);
      chk("rst_sel",    32'(sel4r),   32'h0);
      step();
      rst_n = 1'b1;
      #1;
      chk("first_grant4", 32'(ready4r), 32'h1);
      chk("first_grant3", 32'(ready3),  32'h1);

      // Round-robin rotation, one word per cycle
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rr4_sel",  32'(sel4r),   32'(exp_rr4[i]));
         chk("rr4_data", 32'(data4r),  32'h0000A000 + 32'(exp_rr4[i]));
         chk("rr4_vld",  32'(valid4r), 32'h1);
         chk("rr3_sel",  32'(sel3),    32'(exp_rr3[i]));
         chk("fp4_sel",  32'(sel4f),   32'h0);
      end

      // Fixed priority: channel 1 always beats channel 3
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("fp_sel",   32'(sel4f),   32'h1);
         chk("fp_ready", 32'(ready4f), 32'h2);
      end

      // Backpressure holding 0x1234 from channel 2
      in_valid   = 4'b0100;
      in_data[2] = 16'h1234;
      step();
      chk("bp_load_data", 32'(data4r), 32'h1234);
      chk("bp_load_sel",  32'(sel4r),  32'h2);
      in_ready = 1'b0;
      in_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_data",  32'(data4r),  32'h1234);
         chk("bp_sel",   32'(sel4r),   32'h2);
         chk("bp_valid", 32'(valid4r), 32'h1);
         chk("bp_ready", 32'(ready4r), 32'h0);
      end
      in_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(ready4r), 32'h8);
      step();
      chk("bp_reload_valid", 32'(valid4r), 32'h1);
      chk("bp_reload_sel",   32'(sel4r),   32'h3);
      chk("bp_reload_data",  32'(data4r),  32'h0000A003);

      // N=3 pointer wrap after a channel-2 transfer
      in_valid = 4'b0100;
      step();
      chk("wrap_sel2", 32'(sel3), 32'h2);
      in_valid = 4'b0011;
      #1;
      chk("wrap_ready", 32'(ready3), 32'h1);
      step();
      chk("wrap_sel0", 32'(sel3), 32'h0);
      step();
      chk("wrap_sel1", 32'(sel3), 32'h1);

      // Asynchronous reset in the middle of a stream
      in_valid = 4'b1111;
      step();
      step();
      chk("pre_rst_valid", 32'(valid4r), 32'h1);
      #1;
      xfers_snap = xfers;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(valid4r), 32'h0);
      chk("async_ready", 32'(ready4r), 32'h0);
      chk("async_sel",   32'(sel4r),   32'h0);
      step();
      chk("rst_no_xfer", 32'(xfers), 32'(xfers_snap));
      rst_n = 1'b1;
      step();
      chk("post_rst_sel",  32'(sel4r),   32'h0);
      chk("post_rst_data", 32'(data4r),  32'h0000A000);
      step();
      chk("post_rst_sel1", 32'(sel4r),   32'h1);

      // Drain and make sure nothing is left outstanding
      in_valid = 4'b0000;
      repeat (3) step();
      chk("drain_valid", 32'(valid4r), 32'h0);
      chk("sb_empty",    32'(exp_q.size()), 32'h0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
